// File: rtl/intt.sv
// Inverse NTT over Z_q (q = 8380417, n = 256): in-place Gentleman-Sande butterflies,
// one per cycle, then the coefficients are streamed out scaled by n^-1.
module intt (
   input  logic        clk,
   input  logic        rst,
   output logic        input_ready,
   input  logic        input_valid,
   input  logic [22:0] input_data,
   output logic [7:0]  tf_addr,
   input  logic [22:0] tf_data,
   output logic        output_valid,
   output logic [22:0] output_data
);

   localparam logic [23:0] Q24  = 24'd8380417;
   localparam logic [22:0] NINV = 23'd8347681;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CALC, S_OUTPUT} state_t;

   // 2^23 == 2^13 - 1 (mod q): three folds bring any 46-bit product below 2q.
   function automatic logic [22:0] mul_mod(input logic [22:0] a, input logic [22:0] b);
      logic [45:0] p;
      logic [35:0] r1;
      logic [26:0] r2;
      logic [23:0] r3;
      logic [23:0] r3_sub;
      p      = {23'd0, a} * {23'd0, b};
      r1     = {13'd0, p[45:23]} * 36'd8191 + {13'd0, p[22:0]};
      r2     = {14'd0, r1[35:23]} * 27'd8191 + {4'd0, r1[22:0]};
      r3     = {20'd0, r2[26:23]} * 24'd8191 + {1'b0, r2[22:0]};
      r3_sub = r3 - Q24;
      return (r3 >= Q24) ? r3_sub[22:0] : r3[22:0];
   endfunction

   state_t      state_q;
   logic [22:0] mem_q [256];
   logic [7:0]  in_cnt_q, out_cnt_q, m_q, j_q, len_q;
   logic [8:0]  start_q;
   logic        output_valid_q;
   logic [22:0] output_data_q;

   logic        accept;
   logic [7:0]  load_idx, hi_idx;
   logic [22:0] x_val, y_val, add_res, sub_res, tw_neg, bf_res, out_res;
   logic [23:0] sum_d, diff_d, sum_sub, tw_diff;
   logic [8:0]  start_d;
   logic        grp_last, lvl_last, calc_done;

   assign input_ready  = (state_q == S_IDLE || state_q == S_LOAD) && !output_valid_q;
   assign accept       = input_valid && input_ready;
   assign load_idx     = (state_q == S_IDLE) ? 8'd0 : in_cnt_q;
   assign tf_addr      = 8'd255 - m_q;
   assign output_valid = output_valid_q;
   assign output_data  = output_data_q;

   // Butterfly datapath
   assign hi_idx  = j_q + len_q;
   assign x_val   = mem_q[j_q];
   assign y_val   = mem_q[hi_idx];
   assign sum_d   = {1'b0, x_val} + {1'b0, y_val};
   assign sum_sub = sum_d - Q24;
   assign add_res = (sum_d >= Q24) ? sum_sub[22:0] : sum_d[22:0];
   assign diff_d  = (x_val < y_val) ? ({1'b0, x_val} + Q24 - {1'b0, y_val})
                                    : ({1'b0, x_val} - {1'b0, y_val});
   assign sub_res = diff_d[22:0];
   assign tw_diff = Q24 - {1'b0, tf_data};
   assign tw_neg  = (tf_data == 23'd0) ? 23'd0 : tw_diff[22:0];
   assign bf_res  = mul_mod(sub_res, tw_neg);
   assign out_res = mul_mod(mem_q[out_cnt_q], NINV);

   // Schedule bookkeeping: group and level boundaries
   assign start_d   = start_q + {len_q, 1'b0};
   assign grp_last  = ({1'b0, j_q} == start_q + {1'b0, len_q} - 9'd1);
   assign lvl_last  = grp_last && (start_d == 9'd256);
   assign calc_done = lvl_last && (len_q == 8'd128);

   always_ff @(posedge clk) begin
      if (accept) begin
         mem_q[load_idx] <= input_data;
      end else if (state_q == S_CALC) begin
         mem_q[j_q]    <= add_res;
         mem_q[hi_idx] <= bf_res;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         in_cnt_q       <= 8'd0;
         out_cnt_q      <= 8'd0;
         m_q            <= 8'd0;
         j_q            <= 8'd0;
         start_q        <= 9'd0;
         len_q          <= 8'd1;
         output_valid_q <= 1'b0;
         output_data_q  <= 23'd0;
      end else begin
         output_valid_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               in_cnt_q  <= 8'd0;
               out_cnt_q <= 8'd0;
               m_q       <= 8'd0;
               j_q       <= 8'd0;
               start_q   <= 9'd0;
               len_q     <= 8'd1;
               if (accept) begin
                  in_cnt_q <= 8'd1;
                  state_q  <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (accept) begin
                  in_cnt_q <= in_cnt_q + 8'd1;
                  if (in_cnt_q == 8'd255) state_q <= S_CALC;
               end
            end
            S_CALC: begin
               if (grp_last) begin
                  m_q <= m_q + 8'd1;
                  if (lvl_last) begin
                     len_q   <= {len_q[6:0], 1'b0};
                     start_q <= 9'd0;
                     j_q     <= 8'd0;
                  end else begin
                     start_q <= start_d;
                     j_q     <= start_d[7:0];
                  end
                  if (calc_done) state_q <= S_OUTPUT;
               end else begin
                  j_q <= j_q + 8'd1;
               end
            end
            S_OUTPUT: begin
               output_valid_q <= 1'b1;
               output_data_q  <= out_res;
               out_cnt_q      <= out_cnt_q + 8'd1;
               if (out_cnt_q == 8'd255) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_intt.sv
// Directed frames for intt: zero frame, NTT round trip, all q-1, gapped load with
// stray input_valid during compute/output, and a mid-CALC reset followed by a fresh frame.
module tb_intt;

   localparam longint unsigned Q    = 64'd8380417;
   localparam longint unsigned NINV = 64'd8347681;

   logic        clk;
   logic        rst;
   logic        input_ready;
   logic        input_valid;
   logic [22:0] input_data;
   logic [7:0]  tf_addr;
   logic [22:0] tf_data;
   logic        output_valid;
   logic [22:0] output_data;

   logic [22:0] zetas   [256];
   logic [7:0]  exp_tf  [1024];
   logic [22:0] vec_in  [256];
   logic [22:0] vec_exp [256];

   int n_checks = 0;
   int n_errors = 0;

   intt dut (
      .clk          (clk),
      .rst          (rst),
      .input_ready  (input_ready),
      .input_valid  (input_valid),
      .input_data   (input_data),
      .tf_addr      (tf_addr),
      .tf_data      (tf_data),
      .output_valid (output_valid),
      .output_data  (output_data)
   );

   assign tf_data = zetas[tf_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint unsigned pow_mod(input longint unsigned b, input int e);
      longint unsigned r = 1;
      for (int i = 0; i < e; i++) r = (r * b) % Q;
      return r;
   endfunction

   task automatic build_tables();
      int idx = 0;
      int k = 256;
      for (int i = 0; i < 256; i++) begin
         logic [7:0] iv = 8'(i);
         logic [7:0] br;
         for (int b = 0; b < 8; b++) br[b] = iv[7-b];
         zetas[i] = 23'(pow_mod(64'd1753, int'(br)));
      end
      zetas[0] = 23'd0;
      for (int len = 1; len < 256; len <<= 1)
         for (int start = 0; start < 256; start += 2 * len) begin
            k--;
            for (int j = 0; j < len; j++) begin
               exp_tf[idx] = 8'(k);
               idx++;
            end
         end
   endtask

   // Forward Dilithium NTT in standard form, used to build round-trip stimulus.
   task automatic fwd_ntt(input int dummy);
      longint unsigned a [256];
      longint unsigned t, z;
      int k = 0;
      for (int i = 0; i < 256; i++) a[i] = longint'(i) + longint'(dummy);
      for (int len = 128; len > 0; len >>= 1)
         for (int start = 0; start < 256; start += 2 * len) begin
            k++;
            z = longint'(zetas[k]);
            for (int j = start; j < start + len; j++) begin
               t          = (z * a[j+len]) % Q;
               a[j+len]   = (a[j] + Q - t) % Q;
               a[j]       = (a[j] + t) % Q;
            end
         end
      for (int i = 0; i < 256; i++) vec_in[i] = 23'(a[i]);
   endtask

   // Reference inverse NTT (negated twiddles, mirrored order) followed by n^-1 scaling.
   task automatic gold_intt();
      longint unsigned a [256];
      longint unsigned t, u, z;
      int k = 256;
      for (int i = 0; i < 256; i++) a[i] = longint'(vec_in[i]);
      for (int len = 1; len < 256; len <<= 1)
         for (int start = 0; start < 256; start += 2 * len) begin
            k--;
            z = (zetas[k] == 23'd0) ? 64'd0 : Q - longint'(zetas[k]);
            for (int j = start; j < start + len; j++) begin
               t        = a[j];
               u        = a[j+len];
               a[j]     = (t + u) % Q;
               a[j+len] = (((t + Q - u) % Q) * z) % Q;
            end
         end
      for (int i = 0; i < 256; i++) vec_exp[i] = 23'((a[i] * NINV) % Q);
   endtask

   task automatic random_frame();
      for (int i = 0; i < 256; i++) vec_in[i] = 23'($urandom_range(32'd8380416, 32'd0));
   endtask

   task automatic run_frame(input string name, input bit gaps, input bit junk, input int abort_at);
      int wait_cnt = 0;
      while (!input_ready && wait_cnt < 3000) begin
         @(negedge clk);
         wait_cnt++;
      end
      check_eq({name, "_ready_start"}, 32'(input_ready), 32'd1);
      for (int i = 0; i < 256; i++) begin
         if (gaps) begin
            input_valid = 1'b0;
            input_data  = 23'($urandom);
            @(negedge clk);
         end
         input_valid = 1'b1;
         input_data  = vec_in[i];
         @(negedge clk);
      end
      input_valid = 1'b0;
      for (int c = 0; c < 1024; c++) begin
         if (junk) begin
            input_valid = c[0];
            input_data  = 23'($urandom);
         end
         if (c == abort_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            input_valid = 1'b0;
            check_eq({name, "_rst_valid"}, 32'(output_valid), 32'd0);
            check_eq({name, "_rst_ready"}, 32'(input_ready), 32'd1);
            check_eq({name, "_rst_tf_addr"}, 32'(tf_addr), 32'd255);
            $display("frame %s: reset applied at CALC cycle %0d", name, c);
            return;
         end
         check_eq($sformatf("%s_tf_addr[%0d]", name, c), 32'(tf_addr), 32'(exp_tf[c]));
         if (c == 0 || c == 1023)
            check_eq($sformatf("%s_calc_flags[%0d]", name, c), 32'({output_valid, input_ready}), 32'd0);
         @(negedge clk);
      end
      check_eq({name, "_valid_pre_out"}, 32'(output_valid), 32'd0);
      for (int i = 0; i < 256; i++) begin
         if (junk && i < 255) begin
            input_valid = ~input_valid;
            input_data  = 23'($urandom);
         end else begin
            input_valid = 1'b0;
         end
         @(negedge clk);
         check_eq($sformatf("%s_valid[%0d]", name, i), 32'(output_valid), 32'd1);
         check_eq($sformatf("%s_data[%0d]", name, i), 32'(output_data), 32'(vec_exp[i]));
      end
      input_valid = 1'b0;
      @(negedge clk);
      check_eq({name, "_valid_post"}, 32'(output_valid), 32'd0);
      check_eq({name, "_ready_post"}, 32'(input_ready), 32'd1);
      $display("frame %s: 256 coefficients compared, errors so far %0d", name, n_errors);
   endtask

   initial begin
      rst         = 1'b1;
      input_valid = 1'b0;
      input_data  = 23'd0;
      build_tables();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_ready", 32'(input_ready), 32'd1);
      check_eq("rst_valid", 32'(output_valid), 32'd0);
      check_eq("rst_data", 32'(output_data), 32'd0);
      check_eq("rst_tf_addr", 32'(tf_addr), 32'd255);
      rst = 1'b0;
      @(negedge clk);

      // All zeros in -> all zeros out
      for (int i = 0; i < 256; i++) begin
         vec_in[i]  = 23'd0;
         vec_exp[i] = 23'd0;
      end
      run_frame("zero", 1'b0, 1'b0, -1);

      // Round trip: intt(ntt(i)) = i
      fwd_ntt(0);
      for (int i = 0; i < 256; i++) vec_exp[i] = 23'(i);
      run_frame("roundtrip", 1'b0, 1'b0, -1);

      for (int i = 0; i < 256; i++) vec_in[i] = 23'd8380416;
      gold_intt();
      run_frame("all_qm1", 1'b0, 1'b0, -1);

      random_frame();
      gold_intt();
      run_frame("gapped", 1'b1, 1'b1, -1);

      random_frame();
      run_frame("abort", 1'b0, 1'b0, 500);

      random_frame();
      gold_intt();
      run_frame("fresh", 1'b0, 1'b0, -1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/intt.md
# intt

Inverse number-theoretic transform over Z_q, q = 8380417 (2^23 − 2^13 + 1), n = 256. Accepts a 256-coefficient NTT-domain vector, runs the Gentleman–Sande inverse butterfly network in place, and emits the coefficients scaled by n^-1 mod q. It is the decode-side counterpart of the forward `NTT` block. It shares that block's port protocol and reads the same forward twiddle ROM, using mirrored addressing and negated twiddles.

## Interface
- No parameters; q = 8380417, n = 256, n^-1 = 8347681 fixed.
- `clk` in 1 — single clock, all logic on rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `input_ready` out 1 — high in IDLE and LOAD.
- `input_valid` in 1 — word on `input_data` is accepted on an edge where `input_valid && input_ready`.
- `input_data` in 23 — NTT-domain coefficient, must be < q; natural order, index 0 first.
- `tf_addr` out 8 — forward twiddle ROM address, combinational = 255 − m.
- `tf_data` in 23 — forward twiddle zetas[tf_addr], standard (non-Montgomery) form, < q, valid same cycle (asynchronous ROM).
- `output_valid` out 1 — registered, high for 256 consecutive cycles per frame.
- `output_data` out 23 — registered result coefficient, natural order.

## Operation
- Storage: 256×23 register array, in place.
- States: IDLE, LOAD, CALC, OUTPUT.
  - IDLE: clear in_cnt, out_cnt, m, j, start; len=1. An accept stores mem[0] and moves to LOAD.
  - LOAD: each accept stores mem[in_cnt]. After the 256th accept, go to CALC.
  - CALC: one butterfly per cycle (see below), then advance indices:
    - j+1 within a group;
    - at group end: start += 2·len, j = start, m+1;
    - at level end: len <<= 1, start = 0, j = 0.
    - After len=128 completes, go to OUTPUT.
  - OUTPUT: output_data ← mem[out_cnt]·8347681 mod q, output_valid ← 1, out_cnt+1. After out_cnt=255 is issued, go to IDLE. output_valid drops the following edge.
- Butterfly on X = mem[j], Y = mem[j+len], TF' = (tf_data==0) ? 0 : q − tf_data:
  - mem[j] ← (X+Y) mod q
  - mem[j+len] ← ((X−Y) mod q)·TF' mod q
- Arithmetic:
  - Add uses a 24-bit sum, with a conditional subtract of q.
  - Sub adds q when X < Y.
  - Multiply forms a 46-bit product, fully reduced to [0, q−1] combinationally within the cycle. Reduction method is free, but must be exact.
- Level/group schedule:
  - len = 1, 2, 4, …, 128.
  - 256/(2·len) groups per level, len butterflies per group.
  - m runs 0..254 over 255 groups, so tf_addr runs 255 down to 1.
- Inputs ≥ q: results deterministic but unspecified; no X propagation.
- input_valid outside IDLE/LOAD is ignored.

## Timing
- Reset values: input_ready=1, output_valid=0, output_data=0, tf_addr=255, state=IDLE. Memory is not cleared.
- Load: one word per accepting edge; gaps allowed; no timeout.
- Compute: exactly 1024 CALC cycles, starting the cycle after the 256th accept.
- Latency: with the 256th accept on edge E, the 1024 butterflies occur on edges E+1..E+1024. output_valid first goes high after edge E+1025 (carrying index 0) and stays high through index 255.
- No output backpressure.
- Back-to-back frames: input_ready re-asserts the cycle after output_valid falls. No overlap of frames.
- Reset mid-frame (any state): the next edge returns to IDLE with reset outputs. The partial frame is discarded; the next frame must be correct.

## Test plan
- All-zero frame, input_valid held high → 256 zeros on output_data; output_valid high exactly 256 cycles starting edge E+1025.
- Round trip: x[i] = i fed through the forward NTT, whose outputs drive this block → output_data[i] = i for i=0..255.
- All inputs q−1 = 8380416 → every output < q and matches the golden model (Dilithium invntt, non-Montgomery, times 8347681).
- Twiddle schedule: monitor tf_addr during CALC. It holds each value len cycles per level: 255..128 one cycle each, …, and 1 for 128 cycles. Total 1024 cycles.
- input_valid toggling every other cycle with random data → exactly 256 words captured and matching the golden model; input_valid during CALC/OUTPUT has no effect.
- rst for one cycle at CALC cycle 500 → next cycle output_valid=0, input_ready=1; a fresh random frame then matches the golden model.
